// File: rtl/counter_scheduler.sv
// rtl/counter_scheduler.sv - round-robin time-sharing of one tick counter among requesters
module counter_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 28
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     tick_i,
  input  logic [NUM_REQ-1:0]       req_i,
  input  logic [NUM_REQ*CNT_W-1:0] target_i,
  output logic [NUM_REQ-1:0]       gnt_o,
  output logic [NUM_REQ-1:0]       done_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         count_o
);

  localparam int OWN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [CNT_W-1:0]   tgt_arr [NUM_REQ];
  logic               pick_found;
  logic [OWN_W-1:0]   pick_idx;
  logic [OWN_W-1:0]   cand_idx;
  int                 cand;
  logic [NUM_REQ-1:0] owner_oh;

  // Unpack the flattened target bus so a requester index selects its slice directly.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_tgt
    assign tgt_arr[k] = target_i[k*CNT_W +: CNT_W];
  end

  // Round-robin search starting just above the last owner, wrapping around.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(last_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = OWN_W'(cand);
      if (!pick_found && req_i[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Next-state logic: grant, load, count ticks, pulse done, or abort when the owner withdraws.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    target_d = target_q;
    count_d  = count_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          owner_d  = pick_idx;
          target_d = tgt_arr[pick_idx];
          state_d  = S_LOAD;
        end
      end
      S_LOAD: begin
        count_d = '0;
        if (!req_i[owner_q]) begin
          last_d  = owner_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!req_i[owner_q]) begin
          count_d = '0;
          last_d  = owner_q;
          state_d = S_IDLE;
        end else if (tick_i) begin
          // Compare before increment, so the counter never wraps.
          if (count_q == target_q) begin
            count_d = '0;
            state_d = S_DONE;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; last owner resets to the top index so requester 0 wins first.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      last_q   <= OWN_W'(NUM_REQ - 1);
      target_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      target_q <= target_d;
      count_q  <= count_d;
    end
  end

  // Outputs are decoded from registered state, so they drop at once on reset.
  always_comb begin
    owner_oh = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_q;
    gnt_o    = ((state_q == S_LOAD) || (state_q == S_RUN)) ? owner_oh : '0;
    done_o   = (state_q == S_DONE) ? owner_oh : '0;
    busy_o   = (state_q == S_LOAD) || (state_q == S_RUN);
    count_o  = count_q;
  end

endmodule
